// File: rtl/mem_arbiter.sv
// Arbiter for the byte-wide RAM port, shared by instruction fetch and the load/store buffer.
// A granted request runs as 1/2/4 byte accesses and returns little-endian data with a one-cycle ok.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ok,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_ok,
  output logic [31:0] ls_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  localparam logic [1:0] IO_HI  = 2'b11;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_LAST = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        if_vld_q, if_vld_d;
  logic [31:0] if_addr_q, if_addr_d;
  logic        ls_vld_q, ls_vld_d;
  logic        ls_we_q, ls_we_d;
  logic [1:0]  ls_size_q, ls_size_d;
  logic [31:0] ls_addr_q, ls_addr_d;
  logic [31:0] ls_wdata_q, ls_wdata_d;
  logic        last_ls_q, last_ls_d;
  logic        cur_if_q, cur_if_d;
  logic        cur_we_q, cur_we_d;
  logic [31:0] cur_addr_q, cur_addr_d;
  logic [31:0] cur_wdata_q, cur_wdata_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  nm1_q, nm1_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] last_a_q, last_a_d;
  logic        if_ok_q, if_ok_d;
  logic [31:0] if_data_q, if_data_d;
  logic        ls_ok_q, ls_ok_d;
  logic [31:0] ls_rdata_q, ls_rdata_d;

  logic        io_stall;
  logic [31:0] wdata_sh;
  logic [1:0]  cap_idx;
  logic        cap_en;
  logic [31:0] buf_cap;
  logic        if_acc, ls_acc, if_eff, ls_eff, abort;

  function automatic logic [1:0] size_nm1(input logic [1:0] s);
    case (s)
      2'd0:    return 2'd0;
      2'd1:    return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  // RAM port is combinational from state so the IO stall gates the write strobe in the same cycle.
  always_comb begin
    io_stall = (cur_addr_q[17:16] == IO_HI) && io_buffer_full;
    wdata_sh = cur_wdata_q >> {cnt_q, 3'b000};
    mem_a    = (state_q == S_RUN) ? (cur_addr_q + {30'd0, cnt_q}) : last_a_q;
    mem_dout = (state_q == S_RUN && cur_we_q) ? wdata_sh[7:0] : 8'h00;
    mem_wr   = rdy && (state_q == S_RUN) && cur_we_q && !io_stall;
  end

  // The byte on mem_din belongs to the address issued one cycle earlier.
  always_comb begin
    cap_idx = (state_q == S_LAST) ? nm1_q : (cnt_q - 2'd1);
    cap_en  = !cur_we_q && ((state_q == S_RUN && cnt_q != 2'd0) || state_q == S_LAST);
    buf_cap = buf_q | ({24'd0, mem_din} << {cap_idx, 3'b000});
  end

  always_comb begin
    if_acc = if_req && !clear;
    ls_acc = ls_req && !(clear && !ls_we);
    if_eff = (if_vld_q && !clear) || if_acc;
    ls_eff = (ls_vld_q && !(clear && !ls_we_q)) || ls_acc;
    abort  = clear && !cur_we_q;

    state_d     = state_q;
    if_addr_d   = if_acc ? if_addr : if_addr_q;
    ls_we_d     = ls_acc ? ls_we : ls_we_q;
    ls_size_d   = ls_acc ? ls_size : ls_size_q;
    ls_addr_d   = ls_acc ? ls_addr : ls_addr_q;
    ls_wdata_d  = ls_acc ? ls_wdata : ls_wdata_q;
    if_vld_d    = if_vld_q || if_acc;
    ls_vld_d    = ls_vld_q || ls_acc;
    last_ls_d   = last_ls_q;
    cur_if_d    = cur_if_q;
    cur_we_d    = cur_we_q;
    cur_addr_d  = cur_addr_q;
    cur_wdata_d = cur_wdata_q;
    cnt_d       = cnt_q;
    nm1_d       = nm1_q;
    buf_d       = buf_q;
    last_a_d    = last_a_q;
    if_ok_d     = if_ok_q;
    if_data_d   = if_data_q;
    ls_ok_d     = ls_ok_q;
    ls_rdata_d  = ls_rdata_q;

    if (rdy) begin
      if_ok_d    = 1'b0;
      if_data_d  = 32'd0;
      ls_ok_d    = 1'b0;
      ls_rdata_d = 32'd0;
      if_vld_d   = if_eff;
      ls_vld_d   = ls_eff;
      last_a_d   = mem_a;
      if (cap_en) buf_d = buf_cap;

      case (state_q)
        S_IDLE: begin
          // LS normally wins; IF takes its turn right after an LS grant.
          if (ls_eff && (!if_eff || !last_ls_q)) begin
            ls_vld_d    = 1'b0;
            last_ls_d   = 1'b1;
            cur_if_d    = 1'b0;
            cur_we_d    = ls_we_d;
            cur_addr_d  = ls_addr_d;
            cur_wdata_d = ls_wdata_d;
            nm1_d       = size_nm1(ls_size_d);
            cnt_d       = 2'd0;
            buf_d       = 32'd0;
            state_d     = S_RUN;
          end else if (if_eff) begin
            if_vld_d    = 1'b0;
            last_ls_d   = 1'b0;
            cur_if_d    = 1'b1;
            cur_we_d    = 1'b0;
            cur_addr_d  = if_addr_d;
            cur_wdata_d = 32'd0;
            nm1_d       = 2'd3;
            cnt_d       = 2'd0;
            buf_d       = 32'd0;
            state_d     = S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            state_d = S_IDLE;
          end else if (cur_we_q) begin
            if (!io_stall) begin
              if (cnt_q == nm1_q) begin
                state_d = S_IDLE;
                ls_ok_d = 1'b1;
              end else begin
                cnt_d = cnt_q + 2'd1;
              end
            end
          end else if (cnt_q == nm1_q) begin
            state_d = S_LAST;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
        S_LAST: begin
          state_d = S_IDLE;
          if (!abort) begin
            if (cur_if_q) begin
              if_ok_d   = 1'b1;
              if_data_d = buf_cap;
            end else begin
              ls_ok_d    = 1'b1;
              ls_rdata_d = buf_cap;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      if_vld_q    <= 1'b0;
      if_addr_q   <= 32'd0;
      ls_vld_q    <= 1'b0;
      ls_we_q     <= 1'b0;
      ls_size_q   <= 2'd0;
      ls_addr_q   <= 32'd0;
      ls_wdata_q  <= 32'd0;
      last_ls_q   <= 1'b0;
      cur_if_q    <= 1'b0;
      cur_we_q    <= 1'b0;
      cur_addr_q  <= 32'd0;
      cur_wdata_q <= 32'd0;
      cnt_q       <= 2'd0;
      nm1_q       <= 2'd0;
      buf_q       <= 32'd0;
      last_a_q    <= 32'd0;
      if_ok_q     <= 1'b0;
      if_data_q   <= 32'd0;
      ls_ok_q     <= 1'b0;
      ls_rdata_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      if_vld_q    <= if_vld_d;
      if_addr_q   <= if_addr_d;
      ls_vld_q    <= ls_vld_d;
      ls_we_q     <= ls_we_d;
      ls_size_q   <= ls_size_d;
      ls_addr_q   <= ls_addr_d;
      ls_wdata_q  <= ls_wdata_d;
      last_ls_q   <= last_ls_d;
      cur_if_q    <= cur_if_d;
      cur_we_q    <= cur_we_d;
      cur_addr_q  <= cur_addr_d;
      cur_wdata_q <= cur_wdata_d;
      cnt_q       <= cnt_d;
      nm1_q       <= nm1_d;
      buf_q       <= buf_d;
      last_a_q    <= last_a_d;
      if_ok_q     <= if_ok_d;
      if_data_q   <= if_data_d;
      ls_ok_q     <= ls_ok_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  assign if_ok    = if_ok_q;
  assign if_data  = if_data_q;
  assign ls_ok    = ls_ok_q;
  assign ls_rdata = ls_rdata_q;

endmodule
